ahb_lite_master: RTL
====================

# ahb_lite_master

- Single-outstanding-pipelined AHB-Lite initiator for the on-chip bus: the synthesizable counterpart of the `ram` responder.
- Converts a simple valid/ready command stream (read/write word) into NONSEQ single transfers.
- Overlaps address and data phases, honours HREADY wait states and HRESP errors, and returns one response per command in order.
- Sits between on-chip processing logic and the shared AHB-Lite fabric driving `ram`.

## Interface
- ADDR_WIDTH, 10, byte address width of HADDR/cmd_addr
- DATA_WIDTH, 32, HWDATA/HRDATA width; fixed word transfers
- HCLK  in  1  bus clock, all logic on rising edge
- HRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on edge where valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse per completed transfer
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_error  out  1  transfer ended with HRESP=ERROR
- HSEL  out  1  select for single-slave hookup, equals HTRANS[1]
- HADDR  out  ADDR_WIDTH  address phase address
- HTRANS  out  2  IDLE(00) or NONSEQ(10) only
- HWRITE  out  1  address phase direction
- HSIZE  out  3  constant 3'b010 (word)
- HWDATA  out  DATA_WIDTH  data phase write data
- HRDATA  in  DATA_WIDTH  read data from slave
- HREADY  in  1  transfer-done / wait-state (slave HREADYOUT)
- HRESP  in  1  0=OKAY, 1=ERROR

## Operation
- Two registered phase trackers:
  - Address phase, with states APH_IDLE / APH_ACTIVE.
  - Data phase, with states DPH_IDLE / DPH_READ / DPH_WRITE.
- cmd_ready = !HRESET && (APH_IDLE || HREADY).
- On acceptance, at the next edge the address-phase registers load:
  - HTRANS=NONSEQ, HSEL=1, HWRITE=cmd_write.
  - HADDR=cmd_addr with bits [1:0] forced to 0.
  - The write data is held internally.
- An address phase completes at an edge with HREADY=1. At that edge:
  - The data phase loads DPH_READ or DPH_WRITE.
  - For writes, HWDATA loads the held data and is held stable until the data phase completes.
  - If no command is accepted at the same edge, HTRANS→IDLE, HSEL→0; HADDR/HWRITE hold their last values.
- A data phase completes at an edge with HREADY=1. At that edge:
  - rsp_valid is set for exactly one cycle.
  - rsp_error is set to HRESP.
  - rsp_rdata is set to HRDATA for reads, 0 for writes.
- Responses carry no backpressure; the consumer must take every pulse.
- Error response (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1):
  - The pending address phase is not cancelled and proceeds normally.
  - Only the erroring transfer reports rsp_error=1.
- Back-to-back commands sustain one transfer per cycle with zero wait states.

## Timing
- Reset values:
  - HTRANS=00, HSEL=0, HADDR=0, HWRITE=0, HWDATA=0, HSIZE=3'b010.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, cmd_ready=0.
- Latency with zero wait states: command accepted at edge N; address phase on bus in cycle N..N+1; data phase N+1..N+2; rsp_valid high in cycle after edge N+2.
- Each wait state (HREADY=0 during the data phase) adds one cycle. During wait states, address-phase outputs and HWDATA hold.
- HREADY low while only the address phase is active (previous data phase stalled): cmd_ready=0 and the address outputs hold.
- Reset asserted mid-transfer:
  - All phases are dropped immediately and outputs return to reset values.
  - No response is produced for in-flight commands.

## Configuration
- AHB_MASTER_ERR_CNT_EN defined:
  - Adds output err_count (8 bits).
  - Increments on every rsp_valid with rsp_error=1 and saturates at 255.
  - Reset value 0.
- AHB_MASTER_ERR_CNT_EN undefined: the port and counter do not exist; all other behaviour is identical.

## Structure
- Shared package ahb_pkg:
  - htrans_t enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11).
  - HSIZE_WORD=3'b010.
  - HRESP_OKAY=1'b0, HRESP_ERROR=1'b1.
  - Phase-state enums.
- Single flat module; no sub-module is warranted.

## Test plan
- Write 0x008←0x12345678, then read 0x008 against `ram`, zero waits → rsp_valid two cycles after each accept; read returns 0x12345678, rsp_error=0.
- Four back-to-back commands (writes 0x000←0xA5A5A5A5, 0x00C←0x87654321; reads 0x000, 0x00C) → HTRANS=NONSEQ for four consecutive cycles; responses in order with correct data.
- Command addr 0x01F, write 0x88888888 → HADDR=0x01C, HSIZE=010; read of 0x01C returns 0x88888888.
- Slave model inserts 3 wait states on a write → HWDATA and next HADDR stable for 4 cycles; cmd_ready=0 while stalled; single rsp_valid.
- Two-cycle ERROR response on a read followed by a queued write → read reports rsp_error=1; write completes with rsp_error=0; err_count=1 when the macro is defined.
- HRESET pulsed while a read is in its data phase → outputs at reset values the same cycle; no rsp_valid; a fresh command after release completes normally.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, size/response encodings and
// the phase-tracker state encodings used by the initiator.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;

  typedef enum logic {
    APH_IDLE,
    APH_ACTIVE
  } aph_state_t;

  typedef enum logic [1:0] {
    DPH_IDLE,
    DPH_READ,
    DPH_WRITE
  } dph_state_t;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready read/write-word command stream into
// pipelined NONSEQ single transfers, one outstanding data phase at a time,
// with one in-order response pulse per command.
// Optional: define AHB_MASTER_ERR_CNT_EN to add the saturating err_count output.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
`ifdef AHB_MASTER_ERR_CNT_EN
  output logic [7:0]            err_count,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  HSEL,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  aph_state_t            aph_q, aph_d;
  dph_state_t            dph_q, dph_d;
  logic                  accept;
  logic                  aph_done;
  logic                  dph_done;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic                  unused_addr_lsb;

  // Byte-lane bits are discarded: every transfer is an aligned word.
  assign unused_addr_lsb = ^cmd_addr[1:0];

  assign accept   = cmd_valid && cmd_ready;
  assign aph_done = (aph_q == APH_ACTIVE) && HREADY;
  assign dph_done = (dph_q != DPH_IDLE) && HREADY;

  // Phase-tracker state registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      aph_q <= APH_IDLE;
      dph_q <= DPH_IDLE;
    end else begin
      aph_q <= aph_d;
      dph_q <= dph_d;
    end
  end

  // Next phase states: a new command refills the address phase on the same
  // edge the previous one moves into the data phase.
  always_comb begin
    aph_d = aph_q;
    dph_d = dph_q;
    if (accept) begin
      aph_d = APH_ACTIVE;
    end else if (aph_done) begin
      aph_d = APH_IDLE;
    end
    if (aph_done) begin
      dph_d = HWRITE ? DPH_WRITE : DPH_READ;
    end else if (dph_done) begin
      dph_d = DPH_IDLE;
    end
  end

  // Bus-facing control decoded from the phase states
  always_comb begin
    cmd_ready = !HRESET && ((aph_q == APH_IDLE) || HREADY);
    HTRANS    = (aph_q == APH_ACTIVE) ? NONSEQ : IDLE;
    HSEL      = (aph_q == APH_ACTIVE);
    HSIZE     = HSIZE_WORD;
  end

  // Address-phase and data-phase payload registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      wdata_p0 <= '0;
      HWDATA   <= '0;
    end else begin
      if (accept) begin
        HADDR    <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
        HWRITE   <= cmd_write;
        wdata_p0 <= cmd_wdata;
      end
      if (aph_done && HWRITE) begin
        HWDATA <= wdata_p0;
      end
    end
  end

  // One response pulse per completed data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= dph_done;
      rsp_error <= dph_done && (HRESP != HRESP_OKAY);
      rsp_rdata <= (dph_done && (dph_q == DPH_READ)) ? HRDATA : '0;
    end
  end

`ifdef AHB_MASTER_ERR_CNT_EN
  // Saturating count of error responses
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_count <= 8'd0;
    end else if (rsp_valid && rsp_error && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
